// File: rtl/qlf_k4n8_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : qlf_k4n8_cfg_pkg
//  Brief    : Shared state encodings and parameter limits for K4N8 config loaders
//  Revision : 1.0
// ============================================================================
package qlf_k4n8_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } cfg_state_e;

    localparam int c_nchain_min = 1;
    localparam int c_depth_min  = 2;

endpackage
`default_nettype wire

// File: rtl/qlf_scff_chain.sv
`default_nettype none
// ============================================================================
//  Module   : qlf_scff_chain
//  Brief    : One scan chain of DEPTH config flops with shift enable and reset-to-INIT
//  Revision : 1.0
// ============================================================================
module qlf_scff_chain
    import qlf_k4n8_cfg_pkg::*;
#(
    parameter int   DEPTH = 64,
    parameter logic INIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             si,
    output logic [DEPTH-1:0] q,
    output logic             so
);

    generate
        if (DEPTH < c_depth_min) begin : g_bad_depth
            $error("qlf_scff_chain: DEPTH must be >= 2");
        end
    endgenerate

    logic [DEPTH-1:0] r_q;

    // Flop 0 takes the serial input; the tail flop is the serial output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= {DEPTH{INIT}};
        end else if (en) begin
            r_q <= {r_q[DEPTH-2:0], si};
        end
    end

    assign q  = r_q;
    assign so = r_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/qlf_cfg_chain_loader.sv
`default_nettype none
// ============================================================================
//  Module   : qlf_cfg_chain_loader
//  Brief    : NCHAIN parallel config chains with valid/ready serial load, done and readback
//  Revision : 1.0
// ============================================================================
module qlf_cfg_chain_loader
    import qlf_k4n8_cfg_pkg::*;
#(
    parameter int   NCHAIN = 4,
    parameter int   DEPTH  = 64,
    parameter logic INIT   = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    din_valid,
    output logic                    din_ready,
    input  logic [NCHAIN-1:0]       din,
    output logic [NCHAIN-1:0]       dout,
    output logic [NCHAIN*DEPTH-1:0] cfg_q,
    output logic                    busy,
    output logic                    done
);

    localparam int                 c_cnt_w    = $clog2(DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEPTH - 1);

    generate
        if (NCHAIN < c_nchain_min || DEPTH < c_depth_min) begin : g_bad_params
            $error("qlf_cfg_chain_loader: NCHAIN must be >= 1 and DEPTH >= 2");
        end
    endgenerate

    cfg_state_e         r_state;
    cfg_state_e         w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               w_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Abort outranks a coincident beat, so a cancelled cycle never shifts.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SHIFT;
                    w_cnt_nxt   = '0;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (din_valid) begin
                    if (r_cnt == c_cnt_last) begin
                        w_state_nxt = ST_DONE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_w'(1);
                    end
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_SHIFT;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign din_ready = (r_state == ST_SHIFT);
    assign busy      = (r_state == ST_SHIFT);
    assign done      = (r_state == ST_DONE);
    assign w_shift   = din_ready & din_valid & ~abort;

    generate
        for (genvar c = 0; c < NCHAIN; c++) begin : g_chain
            qlf_scff_chain #(
                .DEPTH (DEPTH),
                .INIT  (INIT)
            ) u_chain (
                .clk (clk),
                .rst (rst),
                .en  (w_shift),
                .si  (din[c]),
                .q   (cfg_q[c*DEPTH +: DEPTH]),
                .so  (dout[c])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_qlf_cfg_chain_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_qlf_cfg_chain_loader
//  Brief    : Scoreboard bench for qlf_cfg_chain_loader (NCHAIN=2, DEPTH=4)
//  Revision : 1.0
// ============================================================================
module tb_qlf_cfg_chain_loader;

    localparam int N = 2;
    localparam int D = 4;

    logic           clk = 1'b0;
    logic           rst, start, abort, din_valid;
    logic [N-1:0]   din;
    logic           din_ready, busy, done;
    logic [N-1:0]   dout;
    logic [N*D-1:0] cfg_q;

    logic           rst1, start1, abort1, din_valid1;
    logic [N-1:0]   din1;
    logic           din_ready1, busy1, done1;
    logic [N-1:0]   dout1;
    logic [N*D-1:0] cfg_q1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [N-1:0]   exp_dout_q[$];
    logic [N*D-1:0] exp_cfg_q[$];
    logic [N*D-1:0] exp_flops;
    logic           prev_done = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    qlf_cfg_chain_loader #(.NCHAIN(N), .DEPTH(D), .INIT(1'b0)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .din_valid(din_valid),
        .din_ready(din_ready), .din(din), .dout(dout), .cfg_q(cfg_q), .busy(busy), .done(done)
    );

    qlf_cfg_chain_loader #(.NCHAIN(N), .DEPTH(D), .INIT(1'b1)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .abort(abort1), .din_valid(din_valid1),
        .din_ready(din_ready1), .din(din1), .dout(dout1), .cfg_q(cfg_q1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Chain c flop i after m beats from contents f: newest beat sits at flop 0.
    function automatic logic [N*D-1:0] after_beats(input logic [N*D-1:0] f,
                                                   input logic [N-1:0] b [D], input int m);
        logic [N*D-1:0] r;
        for (int c = 0; c < N; c++)
            for (int i = 0; i < D; i++)
                r[c*D+i] = (i < m) ? b[m-1-i][c] : f[c*D+i-m];
        return r;
    endfunction

    // Readback before beat k shows flop D-1-k of the contents present at load start.
    function automatic logic [N-1:0] readback(input logic [N*D-1:0] f, input int k);
        logic [N-1:0] r;
        for (int c = 0; c < N; c++) r[c] = f[c*D + D-1-k];
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (din_valid && din_ready && !abort) begin
                if (exp_dout_q.size() == 0) chk("unexpected_beat", 64'd1, 64'd0);
                else chk("dout_readback", 64'(dout), 64'(exp_dout_q.pop_front()));
            end
            if (done && !prev_done) begin
                if (exp_cfg_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
                else chk("cfg_at_done", 64'(cfg_q), 64'(exp_cfg_q.pop_front()));
            end
        end
        prev_done = done;
    end

    task automatic do_load(input logic [N-1:0] b [D], input int gap_idx, input int gap_len,
                           input int abort_at);
        logic [N*D-1:0] f;
        int m;
        f = exp_flops;
        m = (abort_at < D) ? abort_at : D;
        if (m == D) exp_cfg_q.push_back(after_beats(f, b, D));
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("ready_after_start", 64'(din_ready), 64'd1);
        chk("done_after_start", 64'(done), 64'd0);
        for (int k = 0; k < m; k++) begin
            if (k == gap_idx) begin
                for (int g = 0; g < gap_len; g++) begin
                    din_valid = 1'b0;
                    start     = 1'($urandom % 2);
                    @(posedge clk); #1;
                    start = 1'b0;
                    chk("gap_hold", 64'(cfg_q), 64'(after_beats(f, b, k)));
                    chk("gap_busy", 64'(busy), 64'd1);
                end
            end
            din_valid = 1'b1;
            din       = b[k];
            exp_dout_q.push_back(readback(f, k));
            chk("done_low_in_load", 64'(done), 64'd0);
            @(posedge clk); #1;
        end
        din_valid = 1'b0;
        exp_flops = after_beats(f, b, m);
        if (m < D) begin
            din_valid = 1'b1;
            abort     = 1'b1;
            din       = 2'($urandom);
            @(posedge clk); #1;
            abort     = 1'b0;
            din_valid = 1'b0;
            chk("abort_busy", 64'(busy), 64'd0);
            chk("abort_done", 64'(done), 64'd0);
            chk("abort_ready", 64'(din_ready), 64'd0);
            chk("abort_no_shift", 64'(cfg_q), 64'(exp_flops));
        end else begin
            chk("done_after_last", 64'(done), 64'd1);
            chk("busy_after_last", 64'(busy), 64'd0);
            chk("ready_after_last", 64'(din_ready), 64'd0);
            // In DONE both abort and a stray beat must be ignored.
            din_valid = 1'b1;
            abort     = 1'b1;
            din       = 2'($urandom);
            @(posedge clk); #1;
            din_valid = 1'b0;
            abort     = 1'b0;
            chk("done_holds", 64'(done), 64'd1);
            chk("done_cfg_holds", 64'(cfg_q), 64'(exp_flops));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] b [D];
        logic [N-1:0] z [D];
        rst = 1'b1; start = 1'b0; abort = 1'b0; din_valid = 1'b0; din = '0;
        rst1 = 1'b1; start1 = 1'b0; abort1 = 1'b0; din_valid1 = 1'b0; din1 = '0;
        @(posedge clk); #1;
        rst = 1'b0; rst1 = 1'b0;

        chk("rst_cfg", 64'(cfg_q), 64'h00);
        chk("rst_dout", 64'(dout), 64'h0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ready", 64'(din_ready), 64'd0);
        chk("rst_cfg_init1", 64'(cfg_q1), 64'hFF);
        chk("rst_dout_init1", 64'(dout1), 64'h3);
        exp_flops = '0;

        din_valid = 1'b1; din = 2'b11;
        @(posedge clk); #1;
        din_valid = 1'b0;
        chk("idle_valid_ignored", 64'(cfg_q), 64'h00);
        chk("idle_not_busy", 64'(busy), 64'd0);

        b = '{2'b01, 2'b10, 2'b11, 2'b00};
        do_load(b, D, 0, D);
        chk("t2_cfg", 64'(cfg_q), 64'h6A);
        do_load(b, 2, 3, D);
        chk("t3_cfg", 64'(cfg_q), 64'h6A);
        z = '{2'b00, 2'b00, 2'b00, 2'b00};
        do_load(z, D, 0, D);
        chk("t4_cfg", 64'(cfg_q), 64'h00);

        for (int k = 0; k < D; k++) b[k] = 2'($urandom);
        do_load(b, D, 0, 2);
        for (int k = 0; k < D; k++) b[k] = 2'($urandom);
        do_load(b, D, 0, D);

        for (int it = 0; it < 16; it++) begin
            for (int k = 0; k < D; k++) b[k] = 2'($urandom);
            do_load(b, $urandom_range(0, D), $urandom_range(1, 3),
                    ($urandom % 4 == 0) ? $urandom_range(0, D-1) : D);
        end

        // INIT=1 instance: reset lands mid-load with start and a beat both asserted.
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; din_valid1 = 1'b1; din1 = 2'b00;
        repeat (2) begin @(posedge clk); #1; end
        chk("t6_partial", 64'(cfg_q1), 64'hCC);
        rst1 = 1'b1; start1 = 1'b1;
        @(posedge clk); #1;
        chk("t6_cfg", 64'(cfg_q1), 64'hFF);
        chk("t6_busy", 64'(busy1), 64'd0);
        chk("t6_done", 64'(done1), 64'd0);
        chk("t6_ready", 64'(din_ready1), 64'd0);
        rst1 = 1'b0; start1 = 1'b0; din_valid1 = 1'b0;
        @(posedge clk); #1;
        chk("t6_idle_after", 64'(busy1), 64'd0);

        @(posedge clk); #1;
        chk("sb_dout_drain", 64'(exp_dout_q.size()), 64'd0);
        chk("sb_cfg_drain", 64'(exp_cfg_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
